hcsr04_echo_timer: RTL and testbench

HCSR04_ECHO_TIMER -- requirements
Module: hcsr04_echo_timer

---
 rtl/hcsr04_echo_timer.sv | 122 ++++++++++++
 tb/tb_hcsr04_echo_timer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hcsr04_echo_timer.sv
// hcsr04_echo_timer: HC-SR04 trigger generator and echo pulse-width timer
// Ports: ACLK clock; ARESETN async active-low reset; start one-cycle request;
//   echo async sensor echo pin; trig sensor trigger; busy high unless IDLE;
//   echo_us last echo width in us (FFFF on timeout); dist_cm last distance;
//   valid one-cycle result strobe; timeout last measurement timed out.
// Define HCSR04_DIST_CM_EN to enable the centimetre counter (otherwise dist_cm = 0).
module hcsr04_echo_timer #(
  parameter int CLK_DIV    = 100,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 38000,
  parameter int HOLDOFF_US = 60000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic [15:0] echo_us,
  output logic [9:0]  dist_cm,
  output logic        valid,
  output logic        timeout
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;
  state_t state;
  logic [1:0] sync;
  logic echo_d, rise, fall, tick, to_hit, ent_meas, ok_latch, to_latch;
  logic [PW-1:0] pre;
  logic [15:0] cnt;
  assign rise = sync[1] & ~echo_d;
  assign fall = ~sync[1] & echo_d;
  assign tick = pre == PW'(CLK_DIV - 1);
  assign to_hit = tick && cnt == 16'(TIMEOUT_US - 1);
  assign ent_meas = state == WAIT_ECHO && rise;
  assign ok_latch = state == MEASURE && fall;
  // an edge arriving on the very tick that times out still wins
  assign to_latch = to_hit && ((state == WAIT_ECHO && !rise) || (state == MEASURE && !fall));
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= IDLE;
      sync <= '0;
      echo_d <= 1'b0;
      pre <= '0;
      cnt <= '0;
      trig <= 1'b0;
      busy <= 1'b0;
      valid <= 1'b0;
      timeout <= 1'b0;
      echo_us <= '0;
    end else begin
      sync <= {sync[0], echo};
      echo_d <= sync[1];
      valid <= 1'b0;
      pre <= tick ? '0 : pre + 1'b1;
      cnt <= cnt + 16'(tick);
      case (state)
        IDLE: begin
          pre <= '0;
          cnt <= '0;
          if (start) begin
            state <= TRIG;
            trig <= 1'b1;
            busy <= 1'b1;
            timeout <= 1'b0;
          end
        end
        TRIG:
          if (tick && cnt == 16'(TRIG_US - 1)) begin
            state <= WAIT_ECHO;
            trig <= 1'b0;
            pre <= '0;
            cnt <= '0;
          end
        WAIT_ECHO, MEASURE:
          if (ent_meas) begin
            state <= MEASURE;
            pre <= '0;
            cnt <= '0;
          end else if (ok_latch || to_latch) begin
            state <= HOLDOFF;
            pre <= '0;
            cnt <= '0;
            valid <= 1'b1;
            timeout <= to_latch;
            // the falling-edge cycle completes the tick in flight
            echo_us <= to_latch ? 16'hFFFF : cnt + 16'(tick);
          end
        HOLDOFF:
          if (tick && cnt == 16'(HOLDOFF_US - 1)) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef HCSR04_DIST_CM_EN
  logic [5:0] sub;
  logic [9:0] cm;
  logic wrap, cm_inc;
  assign wrap = tick && sub == 6'd57;
  assign cm_inc = wrap && cm != 10'd1023;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      sub <= '0;
      cm <= '0;
      dist_cm <= '0;
    end else begin
      if (ent_meas) begin
        sub <= '0;
        cm <= '0;
      end else if (state == MEASURE) begin
        if (tick) sub <= wrap ? '0 : sub + 1'b1;
        if (cm_inc) cm <= cm + 1'b1;
      end
      if (to_latch) dist_cm <= 10'd1023;
      else if (ok_latch) dist_cm <= cm_inc ? cm + 1'b1 : cm;
    end
`else
  assign dist_cm = '0;
`endif
endmodule

// File: tb/tb_hcsr04_echo_timer.sv
// tb_hcsr04_echo_timer: timeline-model bench for hcsr04_echo_timer
module tb_hcsr04_echo_timer;
  localparam int CLK_DIV = 10, TRIG_US = 10, TIMEOUT_US = 1200, HOLDOFF_US = 50;
  localparam int BIG = 32'h3fffffff;
`ifdef HCSR04_DIST_CM_EN
  localparam bit DIST_EN = 1'b1;
`else
  localparam bit DIST_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, start = 0, echo = 0;
  logic trig, busy, valid, timeout;
  logic [15:0] echo_us;
  logic [9:0] dist_cm;
  int cyc = 0, checks = 0, errors = 0, trig_cnt = 0, valid_cnt = 0;
  bit chk_en = 0;
  int m_s = BIG, m_w = BIG, m_l = BIG, m_h = BIG;
  logic [15:0] m_us = 0, o_us = 0;
  logic [9:0] m_dist = 0, o_dist = 0;
  logic m_to = 0, o_to = 0;

  hcsr04_echo_timer #(.CLK_DIV(CLK_DIV), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
    .HOLDOFF_US(HOLDOFF_US)) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .echo(echo), .trig(trig), .busy(busy),
    .echo_us(echo_us), .dist_cm(dist_cm), .valid(valid), .timeout(timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected outputs after edge cyc, from the current measurement's timeline
  always @(negedge clk) if (chk_en) begin : cmp
    logic e_trig, e_busy, e_valid, e_to;
    logic [15:0] e_us;
    logic [9:0] e_dist;
    e_trig = cyc >= m_s && cyc < m_w;
    e_busy = cyc >= m_s && cyc < m_h;
    e_valid = cyc == m_l;
    e_us = cyc >= m_l ? m_us : o_us;
    e_dist = DIST_EN ? (cyc >= m_l ? m_dist : o_dist) : 10'd0;
    e_to = cyc >= m_l ? m_to : (cyc >= m_s ? 1'b0 : o_to);
    checks++;
    if ({trig, busy, valid, timeout, echo_us, dist_cm} !== {e_trig, e_busy, e_valid, e_to, e_us, e_dist}) begin
      errors++;
      if (errors <= 20)
        $display("FAIL cyc %0d trig/busy/valid/timeout/echo_us/dist_cm got %b/%b/%b/%b/%0d/%0d want %b/%b/%b/%b/%0d/%0d",
          cyc, trig, busy, valid, timeout, echo_us, dist_cm, e_trig, e_busy, e_valid, e_to, e_us, e_dist);
    end
    if (trig) trig_cnt++;
    if (valid) valid_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic bit pat(input int j, r1, f1, r2, f2);
    return (r1 >= 0 && j >= r1 && (f1 < 0 || j < f1)) || (r2 >= 0 && j >= r2 && (f2 < 0 || j < f2));
  endfunction

  task automatic model_reset();
    m_s = BIG; m_w = BIG; m_l = BIG; m_h = BIG;
    m_us = 0; m_dist = 0; m_to = 0;
    o_us = 0; o_dist = 0; o_to = 0;
  endtask

  // One measurement: echo pulses [r1,f1) and [r2,f2) in cycles after start (-1 = none / never falls),
  // extra start pulses at offsets xs1/xs2. Called at a negedge with the DUT idle.
  task automatic run(input int r1, f1, r2, f2, xs1, xs2);
    int s, w, t, r, f, d, us, j;
    s = cyc + 1;
    w = s + TRIG_US * CLK_DIV;
    t = TIMEOUT_US * CLK_DIV;
    r = -1;
    f = -1;
    // an echo rise is seen two cycles later and only counts once trig has ended
    if (r1 >= 0 && s + r1 + 2 > w) begin r = r1; f = f1; end
    else if (r2 >= 0 && s + r2 + 2 > w) begin r = r2; f = f2; end
    o_us = m_us; o_dist = m_dist; o_to = m_to;
    m_s = s;
    m_w = w;
    if (r < 0 || s + r + 2 > w + t) begin
      m_l = w + t; m_us = 16'hFFFF; m_dist = 10'd1023; m_to = 1'b1;
    end else begin
      d = f < 0 ? t + 1 : f - r;
      if (d <= t) begin
        us = d / CLK_DIV;
        m_l = s + r + 2 + d; m_us = 16'(us); m_dist = 10'(us / 58 > 1023 ? 1023 : us / 58); m_to = 1'b0;
      end else begin
        m_l = s + r + 2 + t; m_us = 16'hFFFF; m_dist = 10'd1023; m_to = 1'b1;
      end
    end
    m_h = m_l + HOLDOFF_US * CLK_DIV;
    start = 1'b1;
    echo = pat(0, r1, f1, r2, f2);
    while (cyc < m_h + 3) begin
      @(negedge clk);
      j = cyc + 1 - s;
      start = (j == xs1) || (j == xs2);
      echo = pat(j, r1, f1, r2, f2);
    end
    start = 1'b0;
    echo = 1'b0;
  endtask

  initial begin
    int r, d;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {trig, busy, valid, timeout, echo_us, dist_cm}, 0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    trig_cnt = 0; valid_cnt = 0;
    run(150, 150 + 11600, -1, -1, -1, -1);
    chk("s1_trig_cycles", trig_cnt, 100);
    chk("s2_valid_pulses", valid_cnt, 1);
    chk("s2_echo_us", echo_us, 1160);
    chk("s2_timeout", timeout, 0);
    chk("s2_dist_cm", dist_cm, DIST_EN ? 20 : 0);
    valid_cnt = 0;
    run(-1, -1, -1, -1, -1, -1);
    chk("s3_valid_pulses", valid_cnt, 1);
    chk("s3_echo_us", echo_us, 16'hFFFF);
    chk("s3_timeout", timeout, 1);
    chk("s3_dist_cm", dist_cm, DIST_EN ? 1023 : 0);
    valid_cnt = 0;
    run(120, 720, -1, -1, 400, 900);
    chk("s4_valid_pulses", valid_cnt, 1);
    chk("s4_echo_us", echo_us, 60);
    chk("s4_timeout_cleared", timeout, 0);
    run(40, 150, 300, 757, -1, -1);
    chk("s6_rearmed_echo_us", echo_us, 45);
    run(98, -1, -1, -1, -1, -1);
    chk("s6_stuck_high_timeout", timeout, 1);
    chk("s6_stuck_high_echo_us", echo_us, 16'hFFFF);
    run(99, 99 + 12000, -1, -1, -1, -1);
    chk("edge_full_width_echo_us", echo_us, 1200);
    chk("edge_full_width_timeout", timeout, 0);
    run(200, 200 + 12001, -1, -1, -1, -1);
    chk("measure_timeout_echo_us", echo_us, 16'hFFFF);
    chk("measure_timeout_flag", timeout, 1);
    for (int i = 0; i < 5; i++) begin
      r = $urandom_range(400, 99);
      d = $urandom_range(2000, 1);
      run(r, r + d, -1, -1, -1, -1);
      chk("rand_echo_us", echo_us, d / CLK_DIV);
    end
    run(-1, -1, -1, -1, -1, -1);
    o_us = m_us; o_dist = m_dist; o_to = m_to;
    m_s = cyc + 1; m_w = m_s + TRIG_US * CLK_DIV; m_l = BIG; m_h = BIG;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("s5_trig_before_reset", trig, 1);
    #2;
    chk_en = 0;
    rst_n = 0;
    #1;
    chk("s5_async_trig", trig, 0);
    chk("s5_async_outputs", {busy, valid, timeout, echo_us, dist_cm}, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
    chk_en = 1;
    valid_cnt = 0;
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (60) @(negedge clk);
    echo = 1'b0;
    repeat (200) @(negedge clk);
    chk("s5_no_valid_after_reset", valid_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
